// File: rtl/led_delay_counter_if.sv
// led_delay_counter_if: command/status bundle between the LED-effect controller and the delay counter
interface led_delay_counter_if #(parameter int WIDTH = 32);
  logic             c_reset;
  logic             c_limit_we;
  logic             c_enable;
  logic [WIDTH-1:0] limit_in;
  logic             limit_reached;
  logic [WIDTH-1:0] count;
  logic             busy;
  modport master(output c_reset, c_limit_we, c_enable, limit_in, input limit_reached, count, busy);
  modport slave(input c_reset, c_limit_we, c_enable, limit_in, output limit_reached, count, busy);
endinterface

// File: rtl/led_delay_counter.sv
// led_delay_counter: programmable prescaled delay counter that answers the controller's counter commands
module led_delay_counter #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input logic             clk,
  input logic             reset_n,
  led_delay_counter_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] limit_reg;
  logic [PW-1:0]    presc;
  logic             wrap, hit, stale;
  assign wrap  = presc == PW'(PRESCALE - 1);
  assign hit   = bus.count + WIDTH'(1) == limit_reg;
  // a count already at/over the limit (reload below count) is treated as reached
  assign stale = limit_reg == '0 || bus.count >= limit_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      limit_reg         <= '0;
      presc             <= '0;
      bus.count         <= '0;
      bus.limit_reached <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      if (bus.c_limit_we) limit_reg <= bus.limit_in;
      if (bus.c_reset || bus.c_limit_we) begin
        state             <= IDLE;
        bus.limit_reached <= 1'b0;
        bus.busy          <= 1'b0;
        if (bus.c_reset) begin
          bus.count <= '0;
          presc     <= '0;
        end
      end else if (bus.c_enable && state != DONE) begin
        if (state == IDLE && stale) begin
          state             <= DONE;
          bus.limit_reached <= 1'b1;
        end else begin
          presc <= wrap ? '0 : presc + PW'(1);
          if (wrap) bus.count <= bus.count + WIDTH'(1);
          state             <= wrap && hit ? DONE : COUNT;
          bus.limit_reached <= wrap && hit;
          bus.busy          <= !(wrap && hit);
        end
      end
    end
  end
endmodule

// File: tb/tb_led_delay_counter.sv
// tb_led_delay_counter: directed and random stimulus on PRESCALE=1 and PRESCALE=4 instances against a tick-count model
module tb_led_delay_counter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        c_reset = 1'b0, c_limit_we = 1'b0, c_enable = 1'b0;
  logic [31:0] limit_in = '0;
  always #5 clk = ~clk;
  led_delay_counter_if #(.WIDTH(32)) b1();
  led_delay_counter_if #(.WIDTH(32)) b4();
  assign b1.c_reset = c_reset;
  assign b1.c_limit_we = c_limit_we;
  assign b1.c_enable = c_enable;
  assign b1.limit_in = limit_in;
  assign b4.c_reset = c_reset;
  assign b4.c_limit_we = c_limit_we;
  assign b4.c_enable = c_enable;
  assign b4.limit_in = limit_in;
  led_delay_counter #(.WIDTH(32), .PRESCALE(1)) u1(.clk(clk), .reset_n(reset_n), .bus(b1.slave));
  led_delay_counter #(.WIDTH(32), .PRESCALE(4)) u4(.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  int checks = 0;
  int errors = 0;
  longint pre[2] = '{1, 4};
  // model: total prescaled ticks of the run; count is ticks/PRESCALE, reached when ticks hits limit*PRESCALE
  longint m_ticks[2], m_limit[2];
  bit     m_done[2], m_run[2];
  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ticks[i] = 0; m_limit[i] = 0; m_done[i] = 0; m_run[i] = 0;
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (c_limit_we) m_limit[i] = longint'(limit_in);
      if (c_reset || c_limit_we) begin
        m_done[i] = 0; m_run[i] = 0;
        if (c_reset) m_ticks[i] = 0;
      end else if (c_enable && !m_done[i]) begin
        if (!m_run[i] && (m_limit[i] == 0 || m_ticks[i] / pre[i] >= m_limit[i])) m_done[i] = 1;
        else begin
          m_ticks[i]++;
          m_run[i] = 1;
          if (m_ticks[i] == m_limit[i] * pre[i]) begin
            m_done[i] = 1; m_run[i] = 0;
          end
        end
      end
    end
  endtask
  task automatic check_all();
    check("p1.count", longint'(b1.count), m_ticks[0] / pre[0]);
    check("p1.limit_reached", longint'(b1.limit_reached), longint'(m_done[0]));
    check("p1.busy", longint'(b1.busy), longint'(m_run[0]));
    check("p4.count", longint'(b4.count), m_ticks[1] / pre[1]);
    check("p4.limit_reached", longint'(b4.limit_reached), longint'(m_done[1]));
    check("p4.busy", longint'(b4.busy), longint'(m_run[1]));
  endtask
  task automatic cycle(input logic r, input logic we, input logic en, input logic [31:0] lim);
    c_reset = r; c_limit_we = we; c_enable = en; limit_in = lim;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask
  initial begin
    model_reset();
    #12 check_all();
    reset_n = 1'b1;
    cycle(1, 1, 0, 5);
    cycle(0, 0, 0, 5);
    repeat (15) cycle(0, 0, 1, 5);
    check("p1.hold_count", longint'(b1.count), 5);
    check("p1.hold_reached", longint'(b1.limit_reached), 1);
    cycle(1, 0, 1, 5);
    cycle(0, 0, 1, 5);
    check("p1.after_clear", longint'(b1.count), 1);
    cycle(1, 1, 0, 3);
    repeat (5) cycle(0, 0, 1, 3);
    repeat (6) cycle(0, 0, 0, 3);
    repeat (6) cycle(0, 0, 1, 3);
    check("p4.not_yet", longint'(b4.limit_reached), 0);
    cycle(0, 0, 1, 3);
    check("p4.reached_12", longint'(b4.limit_reached), 1);
    cycle(1, 1, 0, 20);
    repeat (3) cycle(0, 0, 1, 20);
    cycle(0, 1, 0, 8);
    check("p1.reload_keeps", longint'(b1.count), 3);
    repeat (6) cycle(0, 0, 1, 8);
    cycle(1, 1, 0, 0);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 1, 0, 50);
    repeat (4) cycle(0, 0, 1, 50);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 reset_n = 1'b1;
    repeat (400)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 7, 32'($urandom_range(0, 12)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
